// File: rtl/sequential_alu_unit_if.sv
// Bus between the register-file read side, the control unit and sequential_alu_unit.
//   master: drives Start, A, B, FunSel, WF; observes ALUOut, RemOut, FlagsOut, Busy, Done.
//   slave : the ALU itself.
// Signal meanings:
//   Start    - operation request, ignored while Busy
//   A, B     - operands, captured when Start is accepted
//   FunSel   - [5] multi-cycle, [4] full width, [3:0] op code
//   WF       - flag write enable, captured with the operands
//   ALUOut   - result / product low word / quotient
//   RemOut   - remainder / product high word
//   FlagsOut - {O, N, C, Z}
//   Busy     - multi-cycle operation in progress
//   Done     - one-cycle pulse when results and flags update
interface sequential_alu_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [5:0]       FunSel;
   logic             WF;
   logic [WIDTH-1:0] ALUOut;
   logic [WIDTH-1:0] RemOut;
   logic [3:0]       FlagsOut;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, A, B, FunSel, WF,
      input  ALUOut, RemOut, FlagsOut, Busy, Done
   );

   modport slave (
      input  Start, A, B, FunSel, WF,
      output ALUOut, RemOut, FlagsOut, Busy, Done
   );
endinterface

// File: rtl/sequential_alu_unit.sv
// Multi-cycle ALU: 16 single-cycle ops at half or full width with a Z/C/N/O flag register,
// plus iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Ports:
//   Clock - rising-edge clock
//   Reset - asynchronous active-low reset, clears all state
//   bus   - slave side of sequential_alu_unit_if (operands, FunSel, handshake, results)
module sequential_alu_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic                  Clock,
   input logic                  Reset,
   sequential_alu_unit_if.slave bus
);

   localparam int unsigned HALF = WIDTH / 2;
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned IdxW = $clog2(WIDTH);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] alu_out_q, rem_out_q;
   logic [3:0]       flags_q;
   logic             done_q;

   // Multi-cycle operand/working registers
   logic             mc_div_q, mc_wf_q, mc_dz_q;
   logic [WIDTH-1:0] mc_d_q;   // multiplicand or divisor
   logic [WIDTH-1:0] acc_q;    // product high word or partial remainder
   logic [WIDTH-1:0] lo_q;     // multiplier/product low word or dividend/quotient

   logic sc_fire, mc_load, mc_step, mc_last;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.Start && bus.FunSel[5]) state_d = StRun;
         StRun:   if (cnt_q == CntW'(1)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sc_fire = 1'b0;
      mc_load = 1'b0;
      mc_step = 1'b0;
      mc_last = 1'b0;
      case (state_q)
         StIdle: begin
            sc_fire = bus.Start & ~bus.FunSel[5];
            mc_load = bus.Start &  bus.FunSel[5];
         end
         StRun: begin
            mc_step = 1'b1;
            mc_last = (cnt_q == CntW'(1));
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- single-cycle datapath
   logic             half, c_in, c_new, o_new, n_new, z_new;
   logic [3:0]       op;
   logic [IdxW-1:0]  msb;
   logic [WIDTH-1:0] a_z, b_z, r, sc_res;
   logic [WIDTH:0]   sum;
   logic [3:0]       sc_en, sc_new, sc_flags;

   always_comb begin
      half  = ~bus.FunSel[4];
      op    = bus.FunSel[3:0];
      c_in  = flags_q[1];
      msb   = half ? IdxW'(HALF - 1) : IdxW'(WIDTH - 1);
      // Half mode zero-extends so the carry out lands on bit HALF
      a_z   = half ? {{(WIDTH - HALF){1'b0}}, bus.A[HALF-1:0]} : bus.A;
      b_z   = half ? {{(WIDTH - HALF){1'b0}}, bus.B[HALF-1:0]} : bus.B;
      sum   = '0;
      r     = '0;
      c_new = 1'b0;
      o_new = 1'b0;
      case (op)
         4'h0: r = a_z;
         4'h1: r = b_z;
         4'h2: r = ~a_z;
         4'h3: r = ~b_z;
         4'h4, 4'h5: begin
            sum   = {1'b0, a_z} + {1'b0, b_z} + {{WIDTH{1'b0}}, (op == 4'h5) & c_in};
            r     = sum[WIDTH-1:0];
            c_new = half ? sum[HALF] : sum[WIDTH];
            o_new = (a_z[msb] == b_z[msb]) && (r[msb] != a_z[msb]);
         end
         4'h6: begin
            sum   = {1'b0, a_z} - {1'b0, b_z};
            r     = sum[WIDTH-1:0];
            c_new = (a_z >= b_z);  // set on no borrow
            o_new = (a_z[msb] != b_z[msb]) && (r[msb] != a_z[msb]);
         end
         4'h7: r = a_z & b_z;
         4'h8: r = a_z | b_z;
         4'h9: r = a_z ^ b_z;
         4'hA: r = ~(a_z & b_z);
         4'hB: begin
            r     = a_z << 1;
            c_new = a_z[msb];
         end
         4'hC: begin
            r     = a_z >> 1;
            c_new = a_z[0];
         end
         4'hD: begin
            r      = a_z >> 1;
            r[msb] = a_z[msb];
            c_new  = a_z[0];
         end
         4'hE: begin
            r     = (a_z << 1) | {{(WIDTH - 1){1'b0}}, c_in};
            c_new = a_z[msb];
         end
         4'hF: begin
            r      = a_z >> 1;
            r[msb] = c_in;
            c_new  = a_z[0];
         end
      endcase
      sc_res = half ? {{(WIDTH - HALF){r[HALF-1]}}, r[HALF-1:0]} : r;
      n_new  = r[msb];
      z_new  = (sc_res == '0);
      sc_new = {o_new, n_new, c_new, z_new};
      sc_en  = {(op >= 4'h4) && (op <= 4'h6),
                (op != 4'hD),
                ((op >= 4'h4) && (op <= 4'h6)) || (op >= 4'hB),
                1'b1};
      sc_flags = (sc_en & sc_new) | (~sc_en & flags_q);
   end

   // ---------------------------------------------------------------- multi-cycle datapath
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] acc_nxt, lo_nxt, mc_res;
   logic [3:0]       mc_flags;

   always_comb begin
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mc_d_q} : '0);
      div_shift = {acc_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mc_d_q};
      if (mc_div_q) begin
         // Top bit of the difference is the borrow: restore when it is set
         if (!div_diff[WIDTH]) begin
            acc_nxt = div_diff[WIDTH-1:0];
            lo_nxt  = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = div_shift[WIDTH-1:0];
            lo_nxt  = {lo_q[WIDTH-2:0], 1'b0};
         end
         mc_flags = {mc_dz_q, 1'b0, 1'b0, ~mc_dz_q & (lo_nxt == '0)};
      end else begin
         acc_nxt  = mul_sum[WIDTH:1];
         lo_nxt   = {mul_sum[0], lo_q[WIDTH-1:1]};
         mc_flags = {1'b0, lo_nxt[WIDTH-1], (acc_nxt != '0), (lo_nxt == '0)};
      end
      // Divide by zero already yields all ones / A; forced here to make it explicit
      mc_res = (mc_div_q && mc_dz_q) ? '1 : lo_nxt;
   end

   // ---------------------------------------------------------------- state registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cnt_q     <= '0;
         alu_out_q <= '0;
         rem_out_q <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
         mc_div_q  <= 1'b0;
         mc_wf_q   <= 1'b0;
         mc_dz_q   <= 1'b0;
         mc_d_q    <= '0;
         acc_q     <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= sc_fire | mc_last;
         if (sc_fire) begin
            alu_out_q <= sc_res;
            if (bus.WF) flags_q <= sc_flags;
         end
         if (mc_load) begin
            cnt_q    <= CntW'(WIDTH);
            mc_div_q <= bus.FunSel[0];
            mc_wf_q  <= bus.WF;
            mc_dz_q  <= (bus.B == '0);
            mc_d_q   <= bus.FunSel[0] ? bus.B : bus.A;
            acc_q    <= '0;
            lo_q     <= bus.FunSel[0] ? bus.A : bus.B;
         end else if (mc_step) begin
            cnt_q <= cnt_q - CntW'(1);
            acc_q <= acc_nxt;
            lo_q  <= lo_nxt;
         end
         if (mc_last) begin
            alu_out_q <= mc_res;
            rem_out_q <= acc_nxt;
            if (mc_wf_q) flags_q <= mc_flags;
         end
      end
   end

   assign bus.ALUOut   = alu_out_q;
   assign bus.RemOut   = rem_out_q;
   assign bus.FlagsOut = flags_q;
   assign bus.Busy     = (state_q == StRun);
   assign bus.Done     = done_q;

endmodule

// File: tb/tb_sequential_alu_unit.sv
// Directed self-checking bench for sequential_alu_unit at WIDTH = 32.
module tb_sequential_alu_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sequential_alu_unit_if #(.WIDTH(32)) bus ();

   sequential_alu_unit #(.WIDTH(32)) dut (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request at a negedge; return 1 ns after the accepting edge.
   task automatic issue(input logic [5:0] fs, input logic [31:0] a, input logic [31:0] b,
                        input logic wf);
      @(negedge clk);
      bus.Start = 1'b1; bus.FunSel = fs; bus.A = a; bus.B = b; bus.WF = wf;
      @(posedge clk); #1;
      bus.Start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.ALUOut !== 32'h0) begin errors++;
         $display("FAIL reset_aluout got %h want %h", bus.ALUOut, 32'h0); end
      checks++; if (bus.RemOut !== 32'h0) begin errors++;
         $display("FAIL reset_remout got %h want %h", bus.RemOut, 32'h0); end
      checks++; if (bus.FlagsOut !== 4'h0) begin errors++;
         $display("FAIL reset_flags got %b want %b", bus.FlagsOut, 4'h0); end
      checks++; if ({bus.Busy, bus.Done} !== 2'b00) begin errors++;
         $display("FAIL reset_busy_done got %b want %b", {bus.Busy, bus.Done}, 2'b00); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_add_full;
      issue(6'h14, 32'h7FFF_FFFF, 32'h1, 1'b1);
      checks++; if (bus.Done !== 1'b1) begin errors++;
         $display("FAIL add_done got %b want 1", bus.Done); end
      checks++; if (bus.ALUOut !== 32'h8000_0000) begin errors++;
         $display("FAIL add_result got %h want %h", bus.ALUOut, 32'h8000_0000); end
      checks++; if (bus.FlagsOut !== 4'b1100) begin errors++;
         $display("FAIL add_flags got %b want %b", bus.FlagsOut, 4'b1100); end
      @(posedge clk); #1;
      checks++; if (bus.Done !== 1'b0) begin errors++;
         $display("FAIL add_done_pulse got %b want 0", bus.Done); end
   endtask

   task automatic test_sub_half;
      issue(6'h06, 32'h5, 32'h7, 1'b1);
      checks++; if (bus.ALUOut !== 32'hFFFF_FFFE) begin errors++;
         $display("FAIL hsub_result got %h want %h", bus.ALUOut, 32'hFFFF_FFFE); end
      checks++; if (bus.FlagsOut !== 4'b0100) begin errors++;
         $display("FAIL hsub_flags got %b want %b", bus.FlagsOut, 4'b0100); end
   endtask

   task automatic test_csr;
      issue(6'h14, 32'hFFFF_FFFF, 32'h1, 1'b1);  // sets C
      checks++; if (bus.ALUOut !== 32'h0 || bus.FlagsOut !== 4'b0011) begin errors++;
         $display("FAIL carry_add got %h/%b want %h/%b", bus.ALUOut, bus.FlagsOut,
                  32'h0, 4'b0011); end
      issue(6'h1F, 32'h2, 32'h0, 1'b1);
      checks++; if (bus.ALUOut !== 32'h8000_0001) begin errors++;
         $display("FAIL csr_result got %h want %h", bus.ALUOut, 32'h8000_0001); end
      checks++; if (bus.FlagsOut !== 4'b0100) begin errors++;
         $display("FAIL csr_flags got %b want %b", bus.FlagsOut, 4'b0100); end
      issue(6'h1F, 32'h2, 32'h0, 1'b0);
      checks++; if (bus.ALUOut !== 32'h0000_0001) begin errors++;
         $display("FAIL csr_nowf_result got %h want %h", bus.ALUOut, 32'h1); end
      checks++; if (bus.FlagsOut !== 4'b0100) begin errors++;
         $display("FAIL csr_nowf_flags got %b want %b", bus.FlagsOut, 4'b0100); end
      checks++; if (bus.RemOut !== 32'h0) begin errors++;
         $display("FAIL csr_remout got %h want %h", bus.RemOut, 32'h0); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      bus.Start = 1'b1; bus.FunSel = 6'h18; bus.A = 32'hF0; bus.B = 32'h0F; bus.WF = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.ALUOut !== 32'hFF || bus.FlagsOut !== 4'b0000) begin errors++;
         $display("FAIL b2b_or got %h/%b want %h/%b", bus.ALUOut, bus.FlagsOut,
                  32'hFF, 4'b0000); end
      bus.FunSel = 6'h19; bus.A = 32'hFF; bus.B = 32'hFF;
      @(posedge clk); #1;
      bus.Start = 1'b0;
      checks++; if (bus.ALUOut !== 32'h0 || bus.FlagsOut !== 4'b0001 || bus.Done !== 1'b1)
      begin errors++;
         $display("FAIL b2b_xor got %h/%b/%b want %h/%b/1", bus.ALUOut, bus.FlagsOut,
                  bus.Done, 32'h0, 4'b0001); end
   endtask

   task automatic test_asr_half;
      issue(6'h02, 32'h0, 32'h0, 1'b1);  // sets N
      checks++; if (bus.ALUOut !== 32'hFFFF_FFFF || bus.FlagsOut !== 4'b0100) begin errors++;
         $display("FAIL hnot got %h/%b want %h/%b", bus.ALUOut, bus.FlagsOut,
                  32'hFFFF_FFFF, 4'b0100); end
      issue(6'h0D, 32'h4, 32'h0, 1'b1);  // N must hold
      checks++; if (bus.ALUOut !== 32'h2 || bus.FlagsOut !== 4'b0100) begin errors++;
         $display("FAIL hasr got %h/%b want %h/%b", bus.ALUOut, bus.FlagsOut,
                  32'h2, 4'b0100); end
   endtask

   task automatic test_mulu;
      int n;
      int busy_cnt;
      issue(6'h20, 32'hFFFF_FFFF, 32'h2, 1'b1);
      busy_cnt = (bus.Busy === 1'b1) ? 1 : 0;
      n = 0;
      while (bus.Done !== 1'b1 && n < 40) begin
         @(negedge clk);
         if (n == 4) begin  // request while busy must be ignored
            bus.Start = 1'b1; bus.FunSel = 6'h14; bus.A = 32'h1; bus.B = 32'h1; bus.WF = 1'b1;
         end else bus.Start = 1'b0;
         @(posedge clk); #1;
         n++;
         if (bus.Busy === 1'b1) busy_cnt++;
      end
      bus.Start = 1'b0;
      checks++; if (n != 32) begin errors++;
         $display("FAIL mulu_latency got %0d want %0d", n, 32); end
      checks++; if (busy_cnt != 32) begin errors++;
         $display("FAIL mulu_busy_cycles got %0d want %0d", busy_cnt, 32); end
      checks++; if (bus.ALUOut !== 32'hFFFF_FFFE || bus.RemOut !== 32'h1) begin errors++;
         $display("FAIL mulu_result got %h:%h want %h:%h", bus.RemOut, bus.ALUOut,
                  32'h1, 32'hFFFF_FFFE); end
      checks++; if (bus.FlagsOut !== 4'b0110) begin errors++;
         $display("FAIL mulu_flags got %b want %b", bus.FlagsOut, 4'b0110); end
   endtask

   task automatic test_divu;
      int n;
      issue(6'h21, 32'd100, 32'd7, 1'b1);
      n = 0;
      while (bus.Done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      checks++; if (n != 32) begin errors++;
         $display("FAIL divu_latency got %0d want %0d", n, 32); end
      checks++; if (bus.ALUOut !== 32'd14 || bus.RemOut !== 32'd2 || bus.FlagsOut !== 4'b0000)
      begin errors++;
         $display("FAIL divu_result got %h r %h f %b want %h r %h f %b", bus.ALUOut,
                  bus.RemOut, bus.FlagsOut, 32'd14, 32'd2, 4'b0000); end
      // Issued while Done is still high
      issue(6'h21, 32'd9, 32'd0, 1'b1);
      n = 0;
      while (bus.Done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      checks++; if (n != 32) begin errors++;
         $display("FAIL divz_latency got %0d want %0d", n, 32); end
      checks++; if (bus.ALUOut !== 32'hFFFF_FFFF || bus.RemOut !== 32'd9 ||
                    bus.FlagsOut !== 4'b1000) begin errors++;
         $display("FAIL divz_result got %h r %h f %b want %h r %h f %b", bus.ALUOut,
                  bus.RemOut, bus.FlagsOut, 32'hFFFF_FFFF, 32'd9, 4'b1000); end
      issue(6'h14, 32'd2, 32'd3, 1'b1);
      checks++; if (bus.ALUOut !== 32'd5 || bus.RemOut !== 32'd9) begin errors++;
         $display("FAIL remout_hold got %h r %h want %h r %h", bus.ALUOut, bus.RemOut,
                  32'd5, 32'd9); end
   endtask

   task automatic test_reset_mid_run;
      int seen_done;
      issue(6'h20, 32'd3, 32'd5, 1'b1);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.ALUOut !== 32'h0 || bus.RemOut !== 32'h0 || bus.FlagsOut !== 4'h0 ||
                    bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++;
         $display("FAIL midrun_reset got %h %h %b %b %b want all zero", bus.ALUOut,
                  bus.RemOut, bus.FlagsOut, bus.Busy, bus.Done); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      seen_done = 0;
      repeat (40) begin @(posedge clk); #1; if (bus.Done !== 1'b0) seen_done++; end
      checks++; if (seen_done != 0) begin errors++;
         $display("FAIL midrun_no_done got %0d want %0d", seen_done, 0); end
      issue(6'h14, 32'd2, 32'd3, 1'b1);
      checks++; if (bus.ALUOut !== 32'd5 || bus.FlagsOut !== 4'b0000 || bus.Done !== 1'b1)
      begin errors++;
         $display("FAIL post_reset_add got %h/%b/%b want %h/%b/1", bus.ALUOut,
                  bus.FlagsOut, bus.Done, 32'd5, 4'b0000); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.Start = 1'b0; bus.A = '0; bus.B = '0; bus.FunSel = '0; bus.WF = 1'b0;
      test_reset();
      test_add_full();
      test_sub_half();
      test_csr();
      test_back_to_back();
      test_asr_half();
      test_mulu();
      test_divu();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
